// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable synchronous down-counter with one-cycle terminal-count pulse and one-shot/auto-reload modes
module sync_down_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] count_q, reload_q;
   logic             mode_q, tc_q;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else if (stop) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else if (start) begin
         // a zero load is a zero-length count: immediate pulse, never enters RUN
         if (load_val != '0) begin
            state_q  <= RUN;
            count_q  <= load_val;
            reload_q <= load_val;
            mode_q   <= auto_reload;
            tc_q     <= 1'b0;
         end else begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b1;
         end
      end else if (state_q == RUN && en) begin
         if (count_q > WIDTH'(1)) begin
            count_q <= count_q - WIDTH'(1);
            tc_q    <= 1'b0;
         end else begin
            state_q <= mode_q ? RUN : IDLE;
            count_q <= mode_q ? reload_q : '0;
            tc_q    <= 1'b1;
         end
      end else begin
         tc_q <= 1'b0;
      end
   end
   assign q    = count_q;
   assign tc   = tc_q;
   assign busy = (state_q == RUN);
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed self-checking bench for sync_down_timer
module tb_sync_down_timer;
   logic       clk = 1'b0;
   logic       rst, start, stop, en, auto_reload;
   logic [2:0] load_val, q;
   logic       tc, busy;
   int         errors = 0;
   int         checks = 0;

   sync_down_timer #(.WIDTH(3)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
      .auto_reload(auto_reload), .load_val(load_val), .q(q), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] eq, input logic etc, input logic ebusy);
      chk({tag, ".q"}, 32'(q), 32'(eq));
      chk({tag, ".tc"}, 32'(tc), 32'(etc));
      chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
   endtask

   initial begin
      rst = 1'b0; start = 1'b1; stop = 1'b0; en = 1'b1; auto_reload = 1'b0; load_val = 3'd5;
      step(); step();
      chk3("reset", 3'd0, 1'b0, 1'b0);
      rst = 1'b1; start = 1'b0;
      step();
      chk3("post_reset_idle", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd5; auto_reload = 1'b0;
      step();
      chk3("oneshot_load", 3'd5, 1'b0, 1'b1);
      start = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         step();
         chk3("oneshot_cnt", 3'(i), 1'b0, 1'b1);
      end
      step();
      chk3("oneshot_tc", 3'd0, 1'b1, 1'b0);
      step();
      chk3("oneshot_after", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd3; auto_reload = 1'b1;
      step();
      chk3("ar_load", 3'd3, 1'b0, 1'b1);
      start = 1'b0;
      step(); chk3("ar_2", 3'd2, 1'b0, 1'b1);
      step(); chk3("ar_1", 3'd1, 1'b0, 1'b1);
      step(); chk3("ar_reload", 3'd3, 1'b1, 1'b1);
      step(); chk3("ar_2b", 3'd2, 1'b0, 1'b1);
      en = 1'b0;
      step(); chk3("freeze_a", 3'd2, 1'b0, 1'b1);
      step(); chk3("freeze_b", 3'd2, 1'b0, 1'b1);
      en = 1'b1;
      step(); chk3("ar_1b", 3'd1, 1'b0, 1'b1);
      step(); chk3("ar_reload_b", 3'd3, 1'b1, 1'b1);
      stop = 1'b1;
      step(); chk3("ar_stop", 3'd0, 1'b0, 1'b0);
      stop = 1'b0;

      start = 1'b1; load_val = 3'd7; auto_reload = 1'b0;
      step();
      chk3("max_load", 3'd7, 1'b0, 1'b1);
      start = 1'b0;
      for (int i = 6; i >= 1; i--) begin
         step();
         chk3("max_cnt", 3'(i), 1'b0, 1'b1);
      end
      step(); chk3("max_tc", 3'd0, 1'b1, 1'b0);
      step(); chk3("max_nowrap", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd0;
      step(); chk3("zero_tc", 3'd0, 1'b1, 1'b0);
      start = 1'b0;
      step(); chk3("zero_after", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd5;
      step(); chk3("abort_load", 3'd5, 1'b0, 1'b1);
      start = 1'b0;
      step(); chk3("abort_q4", 3'd4, 1'b0, 1'b1);
      stop = 1'b1; start = 1'b1; load_val = 3'd6;
      step(); chk3("abort_stop_beats_start", 3'd0, 1'b0, 1'b0);
      stop = 1'b0; start = 1'b0;
      step(); chk3("abort_after", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd5;
      step(); chk3("restart_load", 3'd5, 1'b0, 1'b1);
      start = 1'b0;
      step(); chk3("restart_q4", 3'd4, 1'b0, 1'b1);
      start = 1'b1; load_val = 3'd2;
      step(); chk3("restart_q2", 3'd2, 1'b0, 1'b1);
      start = 1'b0;
      step(); chk3("restart_q1", 3'd1, 1'b0, 1'b1);
      step(); chk3("restart_tc", 3'd0, 1'b1, 1'b0);
      step(); chk3("restart_after", 3'd0, 1'b0, 1'b0);

      start = 1'b1; load_val = 3'd3; auto_reload = 1'b1;
      step(); chk3("midrst_load", 3'd3, 1'b0, 1'b1);
      start = 1'b0;
      step(); chk3("midrst_q2", 3'd2, 1'b0, 1'b1);
      rst = 1'b0;
      step(); chk3("midrst_reset", 3'd0, 1'b0, 1'b0);
      rst = 1'b1;
      step(); chk3("midrst_after", 3'd0, 1'b0, 1'b0);
      step(); chk3("midrst_after2", 3'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
